// File: rtl/recop_pio_pkg.sv
// Shared constants and types for the ReCOP button/switch input PIO.
package recop_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_DIR      = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    typedef struct packed {
        logic [1:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
    } pio_req_t;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: two-flop synchroniser, persistence counter, stable level and edge detect.
module pio_debounce
    import recop_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_stable,
    output logic o_edge
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_prev   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            r_prev <= r_stable;
            // Any return to the stable level restarts the persistence count.
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_edge = 1'b0;
        case (EDGE_TYPE)
            EDGE_RISING:  o_edge = r_stable & ~r_prev;
            EDGE_FALLING: o_edge = ~r_stable & r_prev;
            default:      o_edge = r_stable ^ r_prev;
        endcase
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/recop_button_pio.sv
// Avalon-MM input PIO: debounced buttons, sticky edge capture, maskable level irq.
module recop_button_pio
    import recop_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    pio_req_t         w_req;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      r_readdata;

    assign w_req.addr  = address;
    assign w_req.rd    = chipselect & ~read_n;
    assign w_req.wr    = chipselect & ~write_n;
    assign w_req.wdata = writedata;
    assign w_unused_wdata = ^writedata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_TYPE      (EDGE_TYPE)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_din   (in_port[g]),
            .o_stable(w_stable[g]),
            .o_edge  (w_edge[g])
        );
    end

    assign w_clr = (w_req.wr && w_req.addr == ADDR_EDGE_CAP) ? w_req.wdata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (w_req.addr)
            ADDR_DATA:     w_rd_mux[WIDTH-1:0] = w_stable;
            ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAP: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
        end else begin
            // OR-ing the new edges after the clear lets a same-cycle set win.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_req.wr && w_req.addr == ADDR_IRQ_MASK)
                r_irq_mask <= w_req.wdata[WIDTH-1:0];
            if (w_req.rd)
                r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
